// File: rtl/dp_mem_port_if.sv
// Bundle of the datapath request/response ports and the request/serve FIFO ports
// used by dp_mem_port. The master modport is the port block; slave is its environment.
interface dp_mem_port_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned TID_WIDTH  = 16,
    parameter int unsigned OUT_AW     = 3
);
    localparam int unsigned REQ_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned SRV_W = TID_WIDTH + DATA_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [TID_WIDTH-1:0]  rsp_tid;
    logic                  rsp_we;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [REQ_W-1:0]      dp_req_data;
    logic                  dp_req_wr;
    logic                  dp_req_full;
    logic [SRV_W-1:0]      dp_srv_data;
    logic                  dp_srv_rd;
    logic                  dp_srv_empty;
    logic [OUT_AW:0]       outstanding;
    logic                  tid_err;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
               dp_req_full, dp_srv_data, dp_srv_empty,
        output req_ready, rsp_valid, rsp_tid, rsp_we, rsp_rdata,
               dp_req_data, dp_req_wr, dp_srv_rd, outstanding, tid_err
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
               dp_req_full, dp_srv_data, dp_srv_empty,
        input  req_ready, rsp_valid, rsp_tid, rsp_we, rsp_rdata,
               dp_req_data, dp_req_wr, dp_srv_rd, outstanding, tid_err
    );
endinterface

// File: rtl/dp_mem_port.sv
// Datapath-side master of the DP<->VPI memory channel: tags requests with TIDs,
// pushes them to the request FIFO and returns in-order serve words as responses.
module dp_mem_port #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned TID_WIDTH  = 16,
    parameter int unsigned OUT_AW     = 3,
    parameter int unsigned TID_BASE   = 0
) (
    input  logic           clk,
    input  logic           rst,
    dp_mem_port_if.master  bus
);
    localparam int unsigned MAX_OUT = 1 << OUT_AW;
    localparam int unsigned CNT_W   = OUT_AW + 1;
    localparam int unsigned SRV_W   = TID_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [TID_WIDTH-1:0]  r_tid_cnt;
    logic [TID_WIDTH-1:0]  r_tag_tid [MAX_OUT];
    logic [MAX_OUT-1:0]    r_tag_we;
    logic [OUT_AW-1:0]     r_wr_ptr;
    logic [OUT_AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_outstanding;
    logic [TID_WIDTH-1:0]  r_rsp_tid;
    logic                  r_rsp_we;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_tid_err;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_tag_empty;
    logic [TID_WIDTH-1:0]  w_srv_tid;
    logic [DATA_WIDTH-1:0] w_srv_word;
    logic [TID_WIDTH-1:0]  w_head_tid;
    logic                  w_head_we;
    logic                  w_srv_rd;
    logic                  w_retire;
    logic                  w_capture;
    logic                  w_err_set;

    assign w_req_ready = !bus.dp_req_full && (r_outstanding < CNT_W'(MAX_OUT));
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_tag_empty = (r_outstanding == '0);
    assign w_srv_tid   = bus.dp_srv_data[SRV_W-1 -: TID_WIDTH];
    assign w_srv_word  = bus.dp_srv_data[DATA_WIDTH-1:0];
    assign w_head_tid  = r_tag_tid[r_rd_ptr];
    assign w_head_we   = r_tag_we[r_rd_ptr];

    assign bus.req_ready   = w_req_ready;
    assign bus.dp_req_wr   = w_accept;
    assign bus.dp_req_data = {r_tid_cnt, bus.req_we, bus.req_addr, bus.req_wdata};
    assign bus.dp_srv_rd   = w_srv_rd;
    assign bus.rsp_valid   = (r_state == S_HOLD);
    assign bus.rsp_tid     = r_rsp_tid;
    assign bus.rsp_we      = r_rsp_we;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.outstanding = r_outstanding;
    assign bus.tid_err     = r_tid_err;

    // Response FSM next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_srv_rd    = 1'b0;
        w_retire    = 1'b0;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.dp_srv_empty) begin
                    w_srv_rd    = 1'b1;
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                if (w_tag_empty) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_capture   = 1'b1;
                    w_retire    = 1'b1;
                    w_err_set   = (w_srv_tid != w_head_tid);
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Tag queue storage; validity is tracked by the pointers and r_outstanding
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_tid[r_wr_ptr] <= r_tid_cnt;
            r_tag_we[r_wr_ptr]  <= bus.req_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tid_cnt     <= TID_WIDTH'(TID_BASE);
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_accept) begin
                r_tid_cnt <= r_tid_cnt + TID_WIDTH'(1);
                r_wr_ptr  <= r_wr_ptr + OUT_AW'(1);
            end
            if (w_retire) r_rd_ptr <= r_rd_ptr + OUT_AW'(1);
            case ({w_accept, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Response capture; the received TID is delivered even on a mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_tid   <= '0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_tid_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_rsp_tid   <= w_srv_tid;
                r_rsp_we    <= w_head_we;
                r_rsp_rdata <= w_srv_word;
            end
            if (w_err_set) r_tid_err <= 1'b1;
        end
    end
endmodule
